// File: rtl/risc_datapath_if.sv
// Controller/memory-facing bundle of the accumulator CPU datapath.
// The master side drives the strobes and memory read data; the slave side is the datapath.
interface risc_datapath_if #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 5
);
    logic              mem_rd;
    logic              load_ir;
    logic              inc_pc;
    logic              load_pc;
    logic              load_ac;
    logic              mem_wr;
    logic              halt;
    logic              sel;
    logic [DWIDTH-1:0] mem_rdata;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_we;
    logic [2:0]        opcode;
    logic              zero;
    logic [AWIDTH-1:0] pc;
    logic              halted;

    modport master (
        output mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, halt, sel, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, opcode, zero, pc, halted
    );

    modport slave (
        input  mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, halt, sel, mem_rdata,
        output mem_addr, mem_wdata, mem_we, opcode, zero, pc, halted
    );
endinterface

// File: rtl/risc_datapath.sv
// Accumulator CPU datapath: PC, IR, AC, ALU and memory port, driven by controller strobes.
// A sticky halt freezes all architectural state until reset.
module risc_datapath #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_,
    risc_datapath_if.slave   bus
);

    if (DWIDTH != 3 + AWIDTH) begin : g_bad_width
        $error("risc_datapath: DWIDTH must equal 3 + AWIDTH");
    end

    typedef enum logic [2:0] {
        OpHlt = 3'd0,
        OpSkz = 3'd1,
        OpAdd = 3'd2,
        OpAnd = 3'd3,
        OpXor = 3'd4,
        OpLda = 3'd5,
        OpSto = 3'd6,
        OpJmp = 3'd7
    } opcode_e;

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] ir_q, ir_d;
    logic [DWIDTH-1:0] ac_q, ac_d;
    logic              halted_q, halted_d;

    logic [AWIDTH-1:0] operand;
    opcode_e           op;
    logic [DWIDTH-1:0] alu_out;

    assign operand = ir_q[AWIDTH-1:0];
    assign op      = opcode_e'(ir_q[DWIDTH-1:AWIDTH]);

    always_comb begin
        alu_out = ac_q;
        unique case (op)
            OpAdd:   alu_out = ac_q + bus.mem_rdata;
            OpAnd:   alu_out = ac_q & bus.mem_rdata;
            OpXor:   alu_out = ac_q ^ bus.mem_rdata;
            OpLda:   alu_out = bus.mem_rdata;
            default: alu_out = ac_q;
        endcase
    end

    // Strobes sampled on the halting edge still act; halted_q gates every later edge.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        ac_d     = ac_q;
        halted_d = halted_q | bus.halt;
        if (!halted_q) begin
            if (bus.load_pc) begin
                pc_d = operand;
            end else if (bus.inc_pc) begin
                pc_d = pc_q + AWIDTH'(1);
            end
            if (bus.load_ir && bus.mem_rd) begin
                ir_d = bus.mem_rdata;
            end
            if (bus.load_ac && bus.mem_rd) begin
                ac_d = alu_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pc_q     <= '0;
            ir_q     <= '0;
            ac_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ac_q     <= ac_d;
            halted_q <= halted_d;
        end
    end

    assign bus.mem_addr  = bus.sel ? pc_q : operand;
    assign bus.mem_wdata = ac_q;
    assign bus.mem_we    = bus.mem_wr & ~halted_q;
    assign bus.opcode    = ir_q[DWIDTH-1:AWIDTH];
    assign bus.zero      = (ac_q == '0);
    assign bus.pc        = pc_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_risc_datapath.sv
// Directed bench for risc_datapath: stimulus queues expected values, a negedge monitor checks them.
module tb_risc_datapath;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 5;

    localparam int unsigned SigPc     = 0;
    localparam int unsigned SigOpcode = 1;
    localparam int unsigned SigZero   = 2;
    localparam int unsigned SigHalted = 3;
    localparam int unsigned SigWe     = 4;
    localparam int unsigned SigAc     = 5;
    localparam int unsigned SigAddr   = 6;

    typedef struct {
        string       name;
        int unsigned sig;
        logic [7:0]  exp;
    } chk_t;

    logic clk;
    logic rst_;
    int   n_checks;
    int   n_fails;
    chk_t sb_q[$];

    risc_datapath_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    risc_datapath #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] probe(input int unsigned s);
        case (s)
            SigPc:     return {3'b000, bus.pc};
            SigOpcode: return {5'b00000, bus.opcode};
            SigZero:   return {7'b0, bus.zero};
            SigHalted: return {7'b0, bus.halted};
            SigWe:     return {7'b0, bus.mem_we};
            SigAc:     return bus.mem_wdata;
            SigAddr:   return {3'b000, bus.mem_addr};
            default:   return 8'hxx;
        endcase
    endfunction

    // Monitor: drain every queued expectation against the outputs mid-cycle.
    always @(negedge clk) begin : monitor
        chk_t       c;
        logic [7:0] act;
        while (sb_q.size() > 0) begin
            c   = sb_q.pop_front();
            act = probe(c.sig);
            n_checks++;
            if (act !== c.exp) begin
                n_fails++;
                $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", c.name, act, c.exp,
                         $time);
            end
        end
    end

    task automatic expect_sig(input string nm, input int unsigned s, input logic [7:0] e);
        chk_t c;
        c.name = nm;
        c.sig  = s;
        c.exp  = e;
        sb_q.push_back(c);
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled on the next one.
    task automatic apply(input logic s, input logic [7:0] rdata, input logic rd, input logic ir,
                         input logic inc, input logic lpc, input logic lac, input logic wr,
                         input logic hlt);
        @(posedge clk);
        #1;
        bus.sel       = s;
        bus.mem_rdata = rdata;
        bus.mem_rd    = rd;
        bus.load_ir   = ir;
        bus.inc_pc    = inc;
        bus.load_pc   = lpc;
        bus.load_ac   = lac;
        bus.mem_wr    = wr;
        bus.halt      = hlt;
    endtask

    task automatic idle(input logic s);
        apply(s, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_state(input string tag);
        expect_sig({tag, "_pc"}, SigPc, 8'h00);
        expect_sig({tag, "_ac"}, SigAc, 8'h00);
        expect_sig({tag, "_opcode"}, SigOpcode, 8'h00);
        expect_sig({tag, "_zero"}, SigZero, 8'h01);
        expect_sig({tag, "_halted"}, SigHalted, 8'h00);
        expect_sig({tag, "_we"}, SigWe, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_     = 1'b0;
        bus.sel = 1'b1; bus.mem_rdata = '0; bus.mem_rd = 0; bus.load_ir = 0; bus.inc_pc = 0;
        bus.load_pc = 0; bus.load_ac = 0; bus.mem_wr = 0; bus.halt = 0;
        idle(1);
        check_reset_state("por");
        idle(1);
        rst_ = 1'b1;

        // Build PC = 7, AC = 0x3C, then assert reset between edges
        apply(1, 8'hA0, 1, 1, 1, 0, 0, 0, 0);
        apply(1, 8'h3C, 1, 0, 1, 0, 1, 0, 0);
        repeat (5) apply(1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        expect_sig("pre_rst_pc", SigPc, 8'h07);
        expect_sig("pre_rst_ac", SigAc, 8'h3C);
        expect_sig("pre_rst_zero", SigZero, 8'h00);
        idle(1);
        rst_ = 1'b0;
        check_reset_state("midrun_rst");
        idle(1);
        rst_ = 1'b1;

        // Fetch/decode at PC = 3
        repeat (3) apply(1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        apply(1, 8'hA5, 1, 1, 0, 0, 0, 0, 0);
        expect_sig("fetch_addr_pc", SigAddr, 8'h03);
        idle(0);
        expect_sig("decode_opcode", SigOpcode, 8'h05);
        expect_sig("decode_addr_operand", SigAddr, 8'h05);

        // ALU
        apply(1, 8'hF0, 1, 0, 0, 0, 1, 0, 0);
        idle(1);
        expect_sig("lda_ac", SigAc, 8'hF0);
        apply(1, 8'h40, 1, 1, 0, 0, 0, 0, 0);
        apply(1, 8'h20, 1, 0, 0, 0, 1, 0, 0);
        idle(1);
        expect_sig("add_ac", SigAc, 8'h10);
        expect_sig("add_zero", SigZero, 8'h00);
        apply(1, 8'h80, 1, 1, 0, 0, 0, 0, 0);
        apply(1, 8'h10, 1, 0, 0, 0, 1, 0, 0);
        idle(1);
        expect_sig("xor_ac", SigAc, 8'h00);
        expect_sig("xor_zero", SigZero, 8'h01);
        apply(1, 8'hA0, 1, 1, 0, 0, 0, 0, 0);
        apply(1, 8'h5A, 1, 0, 0, 0, 1, 0, 0);
        apply(1, 8'h60, 1, 1, 0, 0, 0, 0, 0);
        apply(1, 8'hFF, 1, 0, 0, 0, 1, 0, 0);
        idle(1);
        expect_sig("and_ac", SigAc, 8'h5A);
        // load_ir + load_ac together: AND with old opcode, IR becomes SKZ
        apply(1, 8'h2F, 1, 1, 0, 0, 1, 0, 0);
        idle(1);
        expect_sig("ir_ac_same_edge_ac", SigAc, 8'h0A);
        expect_sig("ir_ac_same_edge_opcode", SigOpcode, 8'h01);
        apply(1, 8'h99, 1, 0, 0, 0, 1, 0, 0);
        idle(1);
        expect_sig("skz_ac_unchanged", SigAc, 8'h0A);
        apply(1, 8'hA0, 1, 1, 0, 0, 0, 0, 0);
        apply(1, 8'h33, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        expect_sig("lac_no_rd_ac", SigAc, 8'h0A);
        apply(1, 8'hE0, 0, 1, 0, 0, 0, 0, 0);
        idle(1);
        expect_sig("lir_no_rd_opcode", SigOpcode, 8'h05);

        // PC control
        apply(1, 8'hFF, 1, 1, 0, 0, 0, 0, 0);
        apply(1, 8'h00, 0, 0, 0, 1, 0, 0, 0);
        idle(1);
        expect_sig("load_pc_31", SigPc, 8'h1F);
        apply(1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        expect_sig("pc_wrap", SigPc, 8'h00);
        apply(1, 8'hF2, 1, 1, 0, 0, 0, 0, 0);
        apply(1, 8'h00, 0, 0, 1, 1, 0, 0, 0);
        idle(1);
        expect_sig("load_beats_inc", SigPc, 8'h12);

        // Store
        apply(1, 8'hA0, 1, 1, 0, 0, 0, 0, 0);
        apply(1, 8'h77, 1, 0, 0, 0, 1, 0, 0);
        apply(1, 8'hC9, 1, 1, 0, 0, 0, 0, 0);
        apply(0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        expect_sig("sto_addr", SigAddr, 8'h09);
        expect_sig("sto_wdata", SigAc, 8'h77);
        expect_sig("sto_we", SigWe, 8'h01);
        idle(0);
        expect_sig("sto_we_drop", SigWe, 8'h00);

        // Halt: the halting edge still honours inc_pc, then everything freezes
        apply(1, 8'hA0, 1, 1, 0, 0, 0, 0, 0);
        apply(1, 8'h00, 0, 0, 1, 0, 0, 0, 1);
        idle(1);
        expect_sig("halt_set", SigHalted, 8'h01);
        expect_sig("halt_edge_inc", SigPc, 8'h13);
        apply(1, 8'h01, 1, 1, 1, 0, 1, 0, 0);
        apply(0, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        expect_sig("halted_we", SigWe, 8'h00);
        idle(1);
        expect_sig("halted_pc", SigPc, 8'h13);
        expect_sig("halted_ac", SigAc, 8'h77);
        expect_sig("halted_opcode", SigOpcode, 8'h05);
        expect_sig("halted_sticky", SigHalted, 8'h01);
        idle(1);
        rst_ = 1'b0;
        check_reset_state("halt_rst");
        idle(1);
        rst_ = 1'b1;
        apply(1, 8'h00, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        expect_sig("resume_pc", SigPc, 8'h01);
        expect_sig("resume_halted", SigHalted, 8'h00);

        repeat (3) idle(1);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
